// File: rtl/dcache_write_buffer_if.sv
// Port bundle for the dcache write-through buffer: store side, bus write side,
// read-miss hazard check and status.
interface dcache_write_buffer_if #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_WIDTH-1:0] write_addr;
    logic [DATA_WIDTH-1:0] write_data;
    logic [1:0]            write_size;
    logic                  write_valid;
    logic                  write_ready;

    logic [ADDR_WIDTH-1:0] bus_addr_write;
    logic [DATA_WIDTH-1:0] bus_data_write;
    logic [3:0]            bus_sel_write;
    logic                  bus_stbw;
    logic                  bus_ackw;

    logic [ADDR_WIDTH-1:0] check_addr;
    logic                  check_hit;
    logic                  empty;
    logic [CNT_W-1:0]      count;
    logic [0:0]            dbg_state;

    // Store handshake: a store transfers on a rising edge with write_valid=1 and
    // write_ready=1; bus write completes on a rising edge with bus_stbw=1 and bus_ackw=1.
    modport slave (
        input  write_addr, write_data, write_size, write_valid, bus_ackw, check_addr,
        output write_ready, bus_addr_write, bus_data_write, bus_sel_write, bus_stbw,
               check_hit, empty, count, dbg_state
    );

    modport master (
        output write_addr, write_data, write_size, write_valid, bus_ackw, check_addr,
        input  write_ready, bus_addr_write, bus_data_write, bus_sel_write, bus_stbw,
               check_hit, empty, count, dbg_state
    );
endinterface

// File: rtl/dcache_write_buffer.sv
// Write-through store buffer: lane-positions dcache stores into a circular FIFO,
// drains them in order over a strobe/ack bus, and flags read-miss word hazards.
module dcache_write_buffer #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    dcache_write_buffer_if.slave  wb
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int WA_W  = ADDR_WIDTH - 2;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_REQ  = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DEPTH-1:0]      vld_q;

    logic [WA_W-1:0]       addr_mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];
    logic [3:0]            sel_mem_q  [DEPTH];

    logic                  push, pop, write_ready, in_req, hit;
    logic [DATA_WIDTH-1:0] push_data;
    logic [3:0]            push_sel;
    logic                  unused_check_lsbs;

    assign unused_check_lsbs = ^wb.check_addr[1:0];

    assign write_ready = (count_q < CNT_W'(DEPTH));
    assign in_req      = (state_q == S_REQ);
    assign push        = wb.write_valid & write_ready;
    assign pop         = in_req & wb.bus_ackw;

    // Half-word placement uses addr[1] only; a stray addr[0] is silently ignored.
    always_comb begin
        push_data = '0;
        push_sel  = '0;
        case (wb.write_size)
            2'd0: begin
                push_data = {24'b0, wb.write_data[7:0]} << {wb.write_addr[1:0], 3'b000};
                push_sel  = 4'b0001 << wb.write_addr[1:0];
            end
            2'd1: begin
                push_data = {16'b0, wb.write_data[15:0]} << {wb.write_addr[1], 4'b0000};
                push_sel  = 4'b0011 << {wb.write_addr[1], 1'b0};
            end
            default: begin
                push_data = wb.write_data;
                push_sel  = 4'hF;
            end
        endcase
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        state_d = state_q;
        if (push) tail_d = tail_q + PTR_W'(1);
        if (pop)  head_d = head_q + PTR_W'(1);
        if (push && !pop) count_d = count_q + CNT_W'(1);
        if (pop && !push) count_d = count_q - CNT_W'(1);
        case (state_q)
            S_IDLE:  if (count_q != '0) state_d = S_REQ;
            S_REQ:   if (pop && count_q == CNT_W'(1)) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            vld_q   <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            // Push and pop never address the same slot: push is refused when full.
            if (pop)  vld_q[head_q] <= 1'b0;
            if (push) vld_q[tail_q] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem_q[tail_q] <= wb.write_addr[ADDR_WIDTH-1:2];
            data_mem_q[tail_q] <= push_data;
            sel_mem_q[tail_q]  <= push_sel;
        end
    end

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && addr_mem_q[i] == wb.check_addr[ADDR_WIDTH-1:2]) hit = 1'b1;
        end
    end

    // Bus fields are forced to zero outside REQ so reset and idle look identical.
    assign wb.bus_stbw       = in_req;
    assign wb.bus_addr_write = in_req ? {addr_mem_q[head_q], 2'b00} : '0;
    assign wb.bus_data_write = in_req ? data_mem_q[head_q] : '0;
    assign wb.bus_sel_write  = in_req ? sel_mem_q[head_q] : '0;
    assign wb.write_ready    = write_ready;
    assign wb.check_hit      = hit;
    assign wb.empty          = (count_q == '0);
    assign wb.count          = count_q;
    assign wb.dbg_state      = state_q;
endmodule
